// File: rtl/mux_uart_if.sv
// rtl/mux_uart_if.sv - CPU6 bus interface for mux_uart (19-bit address, 8-bit data)
interface mux_uart_if;
  logic [18:0] address;
  logic        write_en;
  logic        read_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        selected;

  modport master (
    output address, write_en, read_en, data_in,
    input  data_out, selected
  );

  modport slave (
    input  address, write_en, read_en, data_in,
    output data_out, selected
  );
endinterface

// File: rtl/mux_uart.sv
// rtl/mux_uart.sv - multi-channel 8N1 UART with per-channel TX/RX FIFOs on the CPU6 bus
// Optional interrupt-enable registers and registered irq under MUX_UART_IRQ_EN.
module mux_uart #(
  parameter int          NUM_CHANNELS = 4,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [18:0] BASE_ADDR    = 19'h3f200,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  mux_uart_if.slave               bus,
  output logic [NUM_CHANNELS-1:0] tx,
  input  logic [NUM_CHANNELS-1:0] rx,
  output logic                    irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [7:0]              ch_rdata [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ch_hit;
`ifdef MUX_UART_IRQ_EN
  logic [NUM_CHANNELS-1:0] ch_irq;
`endif

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    localparam logic [18:0] STAT_ADDR = BASE_ADDR + 19'(2 * c);

    logic          st_hit, dt_hit;
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [PW-1:0] tx_wr_q, tx_rd_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [PW-1:0] rx_wr_q, rx_rd_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    uart_state_t   tx_state_q, rx_state_q;
    logic [TW-1:0] tx_tick_q, rx_tick_q;
    logic [2:0]    tx_bit_q, rx_bit_q;
    logic [7:0]    tx_sh_q, rx_sh_q;
    logic          tx_q, rx_meta_q, rx_sync_q, ovr_q, frm_q;
    logic          tx_push, tx_pop, rx_push, rx_pop, rx_done, rx_full, tx_idle;
    logic [7:0]    status;

    assign st_hit   = (bus.address == STAT_ADDR);
    assign dt_hit   = (bus.address == STAT_ADDR + 19'd1);
    assign tx_push  = bus.write_en && dt_hit && (tx_cnt_q != FULL);
    // The serialiser takes the head either from IDLE or at the last stop-bit cycle.
    assign tx_pop   = (tx_cnt_q != '0) &&
                      ((tx_state_q == S_IDLE) || (tx_state_q == S_STOP && tx_tick_q == BIT_END));
    assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    assign rx_pop   = bus.read_en && dt_hit && (rx_cnt_q != '0);
    assign rx_done  = (rx_state_q == S_STOP) && (rx_tick_q == BIT_END);
    assign rx_full  = (rx_cnt_q == FULL) && !rx_pop;
    assign rx_push  = rx_done && rx_sync_q && !rx_full;
    assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    assign tx_idle  = (tx_cnt_q == '0) && (tx_state_q == S_IDLE);
    assign status   = {3'b000, frm_q, ovr_q, tx_idle, tx_cnt_q != FULL, rx_cnt_q != '0};
    assign tx[c]    = tx_q;
    assign ch_rdata[c] = st_hit ? status :
                         (dt_hit && rx_cnt_q != '0) ? rx_mem_q[rx_rd_q] : 8'h00;

    always_ff @(posedge clock) begin
      if (!reset) begin
        tx_wr_q  <= '0;
        tx_rd_q  <= '0;
        tx_cnt_q <= '0;
        rx_wr_q  <= '0;
        rx_rd_q  <= '0;
        rx_cnt_q <= '0;
      end else begin
        if (tx_push) begin
          tx_mem_q[tx_wr_q] <= bus.data_in;
          tx_wr_q           <= tx_wr_q + 1'b1;
        end
        if (tx_pop) tx_rd_q <= tx_rd_q + 1'b1;
        tx_cnt_q <= tx_cnt_d;
        if (rx_push) begin
          rx_mem_q[rx_wr_q] <= rx_sh_q;
          rx_wr_q           <= rx_wr_q + 1'b1;
        end
        if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
        rx_cnt_q <= rx_cnt_d;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        tx_state_q <= S_IDLE;
        tx_tick_q  <= '0;
        tx_bit_q   <= '0;
        tx_sh_q    <= '0;
        tx_q       <= 1'b1;
      end else begin
        case (tx_state_q)
          S_IDLE: begin
            if (tx_pop) begin
              tx_state_q <= S_START;
              tx_sh_q    <= tx_mem_q[tx_rd_q];
              tx_tick_q  <= '0;
              tx_q       <= 1'b0;
            end
          end
          S_START: begin
            if (tx_tick_q == BIT_END) begin
              tx_tick_q  <= '0;
              tx_bit_q   <= '0;
              tx_state_q <= S_DATA;
              tx_q       <= tx_sh_q[0];
            end else begin
              tx_tick_q <= tx_tick_q + 1'b1;
            end
          end
          S_DATA: begin
            if (tx_tick_q == BIT_END) begin
              tx_tick_q <= '0;
              if (tx_bit_q == 3'd7) begin
                tx_state_q <= S_STOP;
                tx_q       <= 1'b1;
              end else begin
                tx_bit_q <= tx_bit_q + 1'b1;
                tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                tx_q     <= tx_sh_q[1];
              end
            end else begin
              tx_tick_q <= tx_tick_q + 1'b1;
            end
          end
          S_STOP: begin
            if (tx_tick_q == BIT_END) begin
              tx_tick_q <= '0;
              if (tx_pop) begin
                tx_state_q <= S_START;
                tx_sh_q    <= tx_mem_q[tx_rd_q];
                tx_q       <= 1'b0;
              end else begin
                tx_state_q <= S_IDLE;
              end
            end else begin
              tx_tick_q <= tx_tick_q + 1'b1;
            end
          end
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        rx_meta_q  <= 1'b1;
        rx_sync_q  <= 1'b1;
        rx_state_q <= S_IDLE;
        rx_tick_q  <= '0;
        rx_bit_q   <= '0;
        rx_sh_q    <= '0;
        ovr_q      <= 1'b0;
        frm_q      <= 1'b0;
      end else begin
        rx_meta_q <= rx[c];
        rx_sync_q <= rx_meta_q;
        // A sticky bit raised on the same edge as a status read survives the clear.
        if (bus.read_en && st_hit) begin
          ovr_q <= 1'b0;
          frm_q <= 1'b0;
        end
        case (rx_state_q)
          S_IDLE: begin
            if (!rx_sync_q) begin
              rx_state_q <= S_START;
              rx_tick_q  <= '0;
            end
          end
          S_START: begin
            if (rx_tick_q == HALF_END) begin
              rx_tick_q  <= '0;
              rx_bit_q   <= '0;
              rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
          S_DATA: begin
            if (rx_tick_q == BIT_END) begin
              rx_tick_q <= '0;
              rx_sh_q   <= {rx_sync_q, rx_sh_q[7:1]};
              if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
              else rx_bit_q <= rx_bit_q + 1'b1;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
          S_STOP: begin
            if (rx_tick_q == BIT_END) begin
              rx_tick_q  <= '0;
              rx_state_q <= S_IDLE;
              if (!rx_sync_q) frm_q <= 1'b1;
              else if (rx_full) ovr_q <= 1'b1;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
          default: rx_state_q <= S_IDLE;
        endcase
      end
    end

`ifdef MUX_UART_IRQ_EN
    localparam logic [18:0] IE_ADDR = BASE_ADDR + 19'(2 * NUM_CHANNELS + c);
    logic       ie_hit;
    logic [1:0] ie_q;

    assign ie_hit = (bus.address == IE_ADDR);

    always_ff @(posedge clock) begin
      if (!reset) ie_q <= 2'b00;
      else if (bus.write_en && ie_hit) ie_q <= bus.data_in[1:0];
    end

    assign ch_hit[c] = st_hit | dt_hit | ie_hit;
    assign ch_irq[c] = (status[0] & ie_q[0]) | (status[2] & ie_q[1]) | ovr_q | frm_q;
`else
    assign ch_hit[c] = st_hit | dt_hit;
`endif
  end

  always_comb begin
    bus.data_out = 8'h00;
    for (int i = 0; i < NUM_CHANNELS; i++) bus.data_out = bus.data_out | ch_rdata[i];
  end

  assign bus.selected = |ch_hit;

`ifdef MUX_UART_IRQ_EN
  logic irq_q;
  always_ff @(posedge clock) begin
    if (!reset) irq_q <= 1'b0;
    else irq_q <= |ch_irq;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mux_uart.sv
// tb/tb_mux_uart.sv - scoreboard testbench for mux_uart with a frame-timing reference model
module tb_mux_uart;
  localparam int NCH = 4;
  localparam int DEPTH = 4;
  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [18:0] BASE = 19'h3f200;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NCH-1:0] tx;
  logic [NCH-1:0] rx;
  logic irq;

  mux_uart_if bus ();

  mux_uart #(
    .NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct { int s; logic [7:0] b; } frame_t;
  typedef struct packed { logic [18:0] a; logic [7:0] d; logic sel; } rd_t;

  logic [7:0] rxq [NCH][$];
  bit         ovr [NCH];
  bit         frm [NCH];
  int         starts [NCH][$];
  int         last_s [NCH];
  bit         has_s [NCH];
  frame_t     exp_tx [NCH][$];
  bit         mon_en [NCH];
  rd_t        sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bytes still waiting in the TX FIFO just before edge t: taken at or after t.
  function automatic int tx_occ(int c, int t);
    int n = 0;
    for (int i = 0; i < starts[c].size(); i++) if (starts[c][i] >= t) n++;
    return n;
  endfunction

  function automatic logic [7:0] model_status(int c, int t);
    logic idle;
    idle = (tx_occ(c, t) == 0) && (!has_s[c] || (t - 1 >= last_s[c] + FRAME));
    return {3'b000, frm[c], ovr[c], idle, tx_occ(c, t) < DEPTH, rxq[c].size() != 0};
  endfunction

  function automatic int pending();
    int n = 0;
    for (int c = 0; c < NCH; c++) n += exp_tx[c].size();
    return n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      rxq[c].delete();
      starts[c].delete();
      exp_tx[c].delete();
      ovr[c] = 0;
      frm[c] = 0;
      has_s[c] = 0;
      last_s[c] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_read(input logic [18:0] a);
    rd_t e;
    int off, c, t;
    t = cyc + 1;
    e.a = a;
    e.d = 8'h00;
    e.sel = 1'b0;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < 2 * NCH) begin
      e.sel = 1'b1;
      c = off / 2;
      if (off % 2 == 0) begin
        e.d = model_status(c, t);
        ovr[c] = 0;
        frm[c] = 0;
      end else if (rxq[c].size() > 0) begin
        e.d = rxq[c].pop_front();
      end
    end
`ifdef MUX_UART_IRQ_EN
    if (off >= 2 * NCH && off < 3 * NCH) e.sel = 1'b1;
`endif
    sb.push_back(e);
    bus.address = a;
    bus.write_en = 1'b0;
    bus.read_en = 1'b1;
    @(posedge clock);
    #1;
    bus.read_en = 1'b0;
  endtask

  task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
    int off, c, n, s;
    n = cyc + 1;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < 2 * NCH && off % 2 == 1) begin
      c = off / 2;
      if (tx_occ(c, n) < DEPTH) begin
        s = n + 1;
        if (has_s[c] && last_s[c] + FRAME > s) s = last_s[c] + FRAME;
        starts[c].push_back(s);
        last_s[c] = s;
        has_s[c] = 1;
        if (mon_en[c]) exp_tx[c].push_back('{s: s, b: d});
      end
    end
    bus.address = a;
    bus.read_en = 1'b0;
    bus.data_in = d;
    bus.write_en = 1'b1;
    @(posedge clock);
    #1;
    bus.write_en = 1'b0;
  endtask

  task automatic send_rx(input int c, input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx[c] = fr[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
    rx[c] = 1'b1;
    if (!stop_ok) frm[c] = 1;
    else if (rxq[c].size() >= DEPTH) ovr[c] = 1;
    else rxq[c].push_back(b);
  endtask

  rd_t mon_e;
  always @(negedge clock) begin
    if (bus.read_en) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd @%h: no expected entry", bus.address);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("rd data @%h", mon_e.a), bus.data_out, mon_e.d);
        check($sformatf("rd selected @%h", mon_e.a), bus.selected, mon_e.sel);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_mon
    initial begin : mon
      logic [7:0] b;
      logic ok;
      int s0;
      frame_t e;
      forever begin
        @(negedge clock);
        if (mon_en[g] && reset && tx[g] === 1'b0) begin
          s0 = cyc;
          ok = 1'b1;
          repeat (CPB / 2) @(negedge clock);
          if (tx[g] !== 1'b0) ok = 1'b0;
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            b[i] = tx[g];
          end
          repeat (CPB) @(negedge clock);
          if (tx[g] !== 1'b1) ok = 1'b0;
          if (exp_tx[g].size() == 0) begin
            check($sformatf("tx%0d frame expected", g), exp_tx[g].size(), 1);
          end else begin
            e = exp_tx[g].pop_front();
            check($sformatf("tx%0d byte", g), b, e.b);
            check($sformatf("tx%0d start edge", g), s0, e.s);
            check($sformatf("tx%0d start/stop levels", g), ok, 1);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, c;
    logic [7:0] b;
    bit ok, seen_low;
    bus.address = '0;
    bus.write_en = 1'b0;
    bus.read_en = 1'b0;
    bus.data_in = '0;
    rx = '1;
    for (int i = 0; i < NCH; i++) mon_en[i] = 1;
    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("reset tx", tx, 4'hf);
    check("reset irq", irq, 0);
    @(posedge clock);
    #1;

    for (int a = 0; a < 2 * NCH; a++) bus_read(BASE + 19'(a));
    bus_read(BASE - 19'd1);
    bus_read(BASE + 19'(2 * NCH));

    bus_write(BASE + 19'd1, 8'h48);
    idle(5);
    bus_read(BASE);
    idle(FRAME + 5);
    bus_read(BASE);

    for (int i = 0; i < 6; i++) bus_write(BASE + 19'd5, 8'($urandom));
    bus_read(BASE + 19'd4);

    fork
      send_rx(1, 8'hA5, 1);
      begin
        idle(3);
        bus_write(BASE + 19'd1, 8'($urandom));
      end
    join
    idle(2);
    bus_read(BASE + 19'd2);
    bus_read(BASE + 19'd3);
    bus_read(BASE + 19'd2);

    for (int i = 0; i < 5; i++) send_rx(3, 8'($urandom), 1);
    idle(2);
    bus_read(BASE + 19'd6);
    bus_read(BASE + 19'd6);
    for (int i = 0; i < 5; i++) bus_read(BASE + 19'd7);
    bus_read(BASE + 19'd6);

    send_rx(0, 8'($urandom), 0);
    idle(4);
`ifdef MUX_UART_IRQ_EN
    check("irq after framing error", irq, 1);
`else
    check("irq after framing error", irq, 0);
`endif
    bus_read(BASE);
    bus_read(BASE + 19'd1);
    bus_read(BASE);

    rx[2] = 1'b0;
    idle(1);
    rx[2] = 1'b1;
    idle(2 * CPB + 4);
    bus_read(BASE + 19'd4);
    bus_read(BASE + 19'd5);

    for (int i = 0; i < 8; i++) begin
      c = $urandom_range(0, NCH - 1);
      b = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      fork
        send_rx(c, b, ok);
        bus_write(BASE + 19'(2 * $urandom_range(0, NCH - 1) + 1), 8'($urandom));
      join
      idle(2);
      bus_read(BASE + 19'(2 * c));
      bus_read(BASE + 19'(2 * c + 1));
      bus_read(BASE + 19'(2 * c));
    end

    k = 0;
    while (pending() != 0 && k < 4000) begin
      idle(1);
      k++;
    end
    idle(FRAME);
    check("all tx frames observed", pending(), 0);
    for (int i = 0; i < NCH; i++) bus_read(BASE + 19'(2 * i));

    mon_en[3] = 0;
    for (int i = 0; i < 3; i++) bus_write(BASE + 19'd7, 8'($urandom));
    idle(10);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("tx after mid-frame reset", tx, 4'hf);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    seen_low = 0;
    repeat (3 * FRAME) begin
      @(negedge clock);
      if (tx !== 4'hf) seen_low = 1;
    end
    check("tx stays idle after reset", seen_low, 0);
    @(posedge clock);
    #1;
    for (int a = 0; a < 2 * NCH; a++) bus_read(BASE + 19'(a));
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
